// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared grade codes, weights, score constants and FSM states for score_accumulator
package score_pkg;

    localparam int SCORE_W   = 20;
    localparam int SCORE_MAX = 1000000;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GREAT   = 2'd1,
        GRADE_PERFECT = 2'd2,
        GRADE_RSVD    = 2'd3
    } grade_e;

    localparam logic [1:0] WEIGHT_MISS    = 2'd0;
    localparam logic [1:0] WEIGHT_GREAT   = 2'd1;
    localparam logic [1:0] WEIGHT_PERFECT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [1:0] grade_weight(input logic [1:0] grade);
        case (grade)
            GRADE_GREAT:   grade_weight = WEIGHT_GREAT;
            GRADE_PERFECT: grade_weight = WEIGHT_PERFECT;
            default:       grade_weight = WEIGHT_MISS;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle, with synchronous clear
module seq_divider #(
    parameter int NUM_W = 34,
    parameter int DEN_W = 13
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;

    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        den_d = den_q;
        cnt_d = cnt_q;
        trial = {rem_q, quo_q[NUM_W-1]};
        diff  = trial - {1'b0, den_q};
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            if (start) begin
                quo_d = dividend;
                rem_d = '0;
                den_d = divisor;
                cnt_d = CNT_W'(NUM_W);
            end
        end else begin
            // Dividend bits shift out of the top of quo_q as quotient bits shift in.
            if (trial >= {1'b0, den_q}) begin
                rem_d = diff[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            den_q <= den_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CNT_W'(1)) && !clear;
    assign quotient = quo_q;

endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-song hit counting and score = SCORE_MAX*weighted/(2*total) via seq_divider
// Optional combo tracking when SCORE_COMBO_EN is defined; otherwise combo/max_combo read 0.
module score_accumulator
    import score_pkg::*;
#(
    parameter int NOTE_W    = 12,
    parameter int SCORE_MAX = score_pkg::SCORE_MAX,
    parameter int NUM_W     = 34
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               song_start,
    input  logic [NOTE_W-1:0]  total_notes,
    input  logic               hit_valid,
    input  logic [1:0]         hit_grade,
    output logic [SCORE_W-1:0] score,
    output logic               score_valid,
    output logic               busy,
    output logic [NOTE_W-1:0]  note_count,
    output logic               song_done,
    output logic [NOTE_W-1:0]  combo,
    output logic [NOTE_W-1:0]  max_combo
);

    localparam int WS_W  = NOTE_W + 1;
    localparam int DEN_W = NOTE_W + 1;
    localparam logic [NUM_W-1:0] SCORE_MAX_N = NUM_W'(SCORE_MAX);

    state_e             state_q, state_d;
    logic [NOTE_W-1:0]  total_q, total_d;
    logic [NOTE_W-1:0]  note_count_q, note_count_d;
    logic [WS_W-1:0]    wsum_q, wsum_d;
    logic               pending_q, pending_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               score_valid_q, score_valid_d;

    logic               accept;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [NUM_W-1:0]   numerator;
    logic [DEN_W-1:0]   denominator;
    logic [NUM_W-1:0]   quotient;
    logic [SCORE_W-1:0] score_sat;

    assign accept = hit_valid && (hit_grade != GRADE_RSVD) && !song_start
                    && (note_count_q < total_q);

    assign numerator   = SCORE_MAX_N * {{(NUM_W-WS_W){1'b0}}, wsum_q};
    assign denominator = {total_q, 1'b0};
    assign score_sat   = (quotient > SCORE_MAX_N) ? SCORE_W'(SCORE_MAX) : quotient[SCORE_W-1:0];

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (song_start),
        .start    (div_start),
        .dividend (numerator),
        .divisor  (denominator),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        note_count_d  = note_count_q;
        wsum_d        = wsum_q;
        pending_d     = pending_q;
        score_d       = score_q;
        score_valid_d = 1'b0;
        div_start     = 1'b0;

        if (accept) begin
            note_count_d = note_count_q + NOTE_W'(1);
            wsum_d       = wsum_q + WS_W'(grade_weight(hit_grade));
        end

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: begin
                div_start = !div_busy;
                state_d   = ST_DIV;
            end
            ST_DIV:  if (div_done) state_d = ST_DONE;
            ST_DONE: begin
                score_d       = score_sat;
                score_valid_d = 1'b1;
                state_d       = (pending_q || accept) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Hits landing mid-computation are folded into one follow-up recompute.
        if (accept && (state_q == ST_LOAD || state_q == ST_DIV))
            pending_d = 1'b1;
        if (state_d == ST_LOAD && state_q != ST_LOAD)
            pending_d = 1'b0;

        if (song_start) begin
            state_d       = ST_IDLE;
            total_d       = total_notes;
            note_count_d  = '0;
            wsum_d        = '0;
            pending_d     = 1'b0;
            score_d       = '0;
            score_valid_d = 1'b0;
            div_start     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            total_q       <= '0;
            note_count_q  <= '0;
            wsum_q        <= '0;
            pending_q     <= 1'b0;
            score_q       <= '0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            note_count_q  <= note_count_d;
            wsum_q        <= wsum_d;
            pending_q     <= pending_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DIV);
    assign note_count  = note_count_q;
    assign song_done   = (note_count_q == total_q) && (total_q != '0);

`ifdef SCORE_COMBO_EN
    logic [NOTE_W-1:0] combo_q, combo_d;
    logic [NOTE_W-1:0] max_combo_q, max_combo_d;

    always_comb begin
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        if (song_start) begin
            combo_d     = '0;
            max_combo_d = '0;
        end else if (accept) begin
            combo_d = (hit_grade == GRADE_MISS) ? '0 : combo_q + NOTE_W'(1);
            if (combo_d > max_combo_q)
                max_combo_d = combo_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    assign combo     = combo_q;
    assign max_combo = max_combo_q;
`else
    assign combo     = '0;
    assign max_combo = '0;
`endif

endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - table-driven directed bench for score_accumulator
module tb_score_accumulator;

    localparam int NOTE_W = 12;
`ifdef SCORE_COMBO_EN
    localparam bit COMBO_ON = 1'b1;
`else
    localparam bit COMBO_ON = 1'b0;
`endif
    localparam logic [1:0] M = 2'd0, G = 2'd1, P = 2'd2, R = 2'd3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              song_start;
    logic [NOTE_W-1:0] total_notes;
    logic              hit_valid;
    logic [1:0]        hit_grade;
    logic [19:0]       score;
    logic              score_valid;
    logic              busy;
    logic [NOTE_W-1:0] note_count;
    logic              song_done;
    logic [NOTE_W-1:0] combo;
    logic [NOTE_W-1:0] max_combo;

    always #5 clk = ~clk;

    score_accumulator dut (
        .clk         (clk),
        .resetn      (resetn),
        .song_start  (song_start),
        .total_notes (total_notes),
        .hit_valid   (hit_valid),
        .hit_grade   (hit_grade),
        .score       (score),
        .score_valid (score_valid),
        .busy        (busy),
        .note_count  (note_count),
        .song_done   (song_done),
        .combo       (combo),
        .max_combo   (max_combo)
    );

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;

    always @(negedge clk) if (score_valid) valid_cnt <= valid_cnt + 1;

    typedef struct {
        int              total;
        int              nh;
        logic [5:0][1:0] g;
        int              gap;
        int              exp_score;
        int              exp_nc;
        int              exp_done;
        int              exp_combo;
        int              exp_max;
        int              vmin;
        int              vmax;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input int total, input int nh,
                                input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] g2,
                                input logic [1:0] g3, input logic [1:0] g4, input logic [1:0] g5,
                                input int gap, input int sc, input int nc, input int dn,
                                input int cb, input int mc, input int vmin, input int vmax);
        vec_t v;
        v.total = total; v.nh = nh; v.gap = gap;
        v.g[0] = g0; v.g[1] = g1; v.g[2] = g2; v.g[3] = g3; v.g[4] = g4; v.g[5] = g5;
        v.exp_score = sc; v.exp_nc = nc; v.exp_done = dn;
        v.exp_combo = COMBO_ON ? cb : 0;
        v.exp_max   = COMBO_ON ? mc : 0;
        v.vmin = vmin; v.vmax = vmax;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic start_song(input int total);
        song_start  = 1'b1;
        total_notes = NOTE_W'(total);
        @(negedge clk);
        song_start  = 1'b0;
    endtask

    task automatic hit(input logic [1:0] g);
        hit_valid = 1'b1;
        hit_grade = g;
        @(negedge clk);
        hit_valid = 1'b0;
        hit_grade = 2'd0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int i = 0; i < 600 && quiet < 3; i++) begin
            @(negedge clk);
            if (busy || score_valid) quiet = 0;
            else quiet++;
        end
        if (quiet < 3) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: busy=%0d after 600 cycles", name, busy);
        end
    endtask

    initial begin
        int base;
        int lat;

        resetn = 1'b0; song_start = 1'b0; total_notes = '0; hit_valid = 1'b0; hit_grade = 2'd0;

        vecs[0] = mk(4, 4, P, P, P, P, M, M, 50, 1000000, 4, 1, 4, 4, 4, 4);
        vecs[1] = mk(3, 3, P, G, M, M, M, M, 50,  500000, 3, 1, 0, 2, 3, 3);
        vecs[2] = mk(3, 3, P, M, M, M, M, M, 50,  333333, 3, 1, 0, 1, 3, 3);
        vecs[3] = mk(2, 3, G, G, G, M, M, M,  0,  500000, 2, 1, 2, 2, 1, 2);
        vecs[4] = mk(0, 2, P, G, M, M, M, M,  5,       0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(4, 3, P, R, G, M, M, M, 50,  375000, 2, 0, 2, 2, 2, 2);
        vecs[6] = mk(3, 1, G, M, M, M, M, M,  0,  166666, 1, 0, 1, 1, 1, 1);
        vecs[7] = mk(5, 5, G, G, G, G, G, M,  0,  500000, 5, 1, 5, 5, 1, 5);

        repeat (3) @(negedge clk);
        chk("reset score", score, 0);
        chk("reset score_valid", score_valid, 0);
        chk("reset busy", busy, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("reset note_count", note_count, 0);
        chk("reset song_done", song_done, 0);
        chk("reset combo", combo, 0);
        chk("reset max_combo", max_combo, 0);

        for (int i = 0; i < 8; i++) begin
            base = valid_cnt;
            start_song(vecs[i].total);
            for (int h = 0; h < vecs[i].nh; h++) begin
                hit(vecs[i].g[h]);
                repeat (vecs[i].gap) @(negedge clk);
            end
            wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d score", i), score, vecs[i].exp_score);
            chk($sformatf("v%0d note_count", i), note_count, vecs[i].exp_nc);
            chk($sformatf("v%0d song_done", i), song_done, vecs[i].exp_done);
            chk($sformatf("v%0d combo", i), combo, vecs[i].exp_combo);
            chk($sformatf("v%0d max_combo", i), max_combo, vecs[i].exp_max);
            chk_range($sformatf("v%0d score_valid pulses", i), valid_cnt - base, vecs[i].vmin, vecs[i].vmax);
        end

        // Latency of an isolated hit: score_valid in cycle t+37.
        start_song(4);
        hit_valid = 1'b1;
        hit_grade = P;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            hit_valid = 1'b0;
            if (score_valid && lat < 0) lat = k;
        end
        chk("latency", lat, 37);
        chk("latency score", score, 250000);

        // Abort a running divide with a new song.
        hit(P);
        repeat (9) @(negedge clk);
        chk("abort busy before", busy, 1);
        base = valid_cnt;
        start_song(5);
        chk("abort busy after", busy, 0);
        chk("abort score", score, 0);
        repeat (60) @(negedge clk);
        chk("abort no score_valid", valid_cnt - base, 0);
        chk("abort note_count", note_count, 0);
        base = valid_cnt;
        hit(P);
        wait_idle("post-abort");
        chk("post-abort score", score, 200000);
        chk("post-abort pulses", valid_cnt - base, 1);
        chk("post-abort note_count", note_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
